// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// uart_tx_scheduler
// Shares the single UART TX line between two byte requesters (0: CPU store
// path, 1: RX echo/debug path). Grants one requester per frame, starts the baud
// generator, shifts 1 start bit, DATA_W data bits (LSB first) and 1 stop bit on
// baud ticks, then waits for the generator's finish pulse before serving again.
//
// Build option: UART_ARB_RR_EN defined -> round-robin tie-break with a 1-bit
// pointer; undefined -> fixed priority, requester 0 wins ties.
//
// Ports:
//   sysclk, reset           clock, asynchronous active-high reset
//   en                      TX enable; gates new grants only
//   reqN_valid/data/ack     requester handshake; ack is a 1-cycle pulse
//   baud_trigger            start request to baud generator (high in TRIG)
//   baud_enable             enable to baud generator, follows en
//   baud_status/tick/finish baud generator running / bit-slot pulse / frame end
//   tx                      serial output, idles high
//   busy                    high whenever not IDLE
//   grant_id                owner of current or most recent frame
//   frame_err, err_clr      sticky early-finish flag and its clear
module uart_tx_scheduler #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              en,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ack,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ack,
  output logic              baud_trigger,
  output logic              baud_enable,
  input  logic              baud_status,
  input  logic              baud_tick,
  input  logic              baud_finish,
  output logic              tx,
  output logic              busy,
  output logic              grant_id,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int unsigned     CNT_W  = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] STOP_K = CNT_W'(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, TRIG, SEND, WAIT_FIN} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              tx_q;
  logic              trig_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              busy_q;
  logic              grant_q;
  logic              err_q;

  logic              any_req_c;
  logic              pick1_c;
  logic              grant_c;

  assign any_req_c = req0_valid | req1_valid;
  assign grant_c   = (state_q == IDLE) & en & any_req_c;

`ifdef UART_ARB_RR_EN
  // Pointer names the preferred requester on a tie; it flips to the loser.
  logic rr_q;

  assign pick1_c = req1_valid & (~req0_valid | rr_q);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (grant_c) begin
      rr_q <= ~pick1_c;
    end
  end
`else
  assign pick1_c = req1_valid & ~req0_valid;
`endif

  // Frame sequencer: grant, trigger, shift on ticks, wait for finish.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      trig_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      // A new error later in this block overrides the clear.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          trig_q <= 1'b0;
          if (grant_c) begin
            shift_q <= pick1_c ? req1_data : req0_data;
            grant_q <= pick1_c;
            ack0_q  <= ~pick1_c;
            ack1_q  <= pick1_c;
            cnt_q   <= '0;
            trig_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= TRIG;
          end
        end
        TRIG: begin
          if (baud_status) begin
            trig_q  <= 1'b0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (baud_tick && (cnt_q == STOP_K)) begin
            // Stop bit; a finish coinciding with it is a normal end of frame.
            tx_q    <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
            busy_q  <= ~baud_finish;
            state_q <= baud_finish ? IDLE : WAIT_FIN;
          end else if (baud_finish) begin
            // Generator ended the frame early: abandon it, no retry.
            err_q   <= 1'b1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (baud_tick) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == '0) begin
              tx_q <= 1'b0;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        WAIT_FIN: begin
          tx_q <= 1'b1;
          if (baud_finish) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ack     = ack0_q;
  assign req1_ack     = ack1_q;
  assign baud_trigger = trig_q;
  assign baud_enable  = en;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// Testbench for uart_tx_scheduler: drives requesters and a baud generator
// model; a scoreboard queue holds the expected grant per frame and a monitor
// compares ack, tx bit stream, busy, grant_id and frame_err every cycle.
module tb_uart_tx_scheduler;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NBITS  = DATA_W + 2;

`ifdef UART_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              sysclk;
  logic              reset;
  logic              en;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ack;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ack;
  logic              baud_trigger;
  logic              baud_enable;
  logic              baud_status;
  logic              baud_tick;
  logic              baud_finish;
  logic              tx;
  logic              busy;
  logic              grant_id;
  logic              frame_err;
  logic              err_clr;

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  logic rr_ptr;

  uart_tx_scheduler #(.DATA_W(DATA_W)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .en          (en),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ack    (req0_ack),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ack    (req1_ack),
    .baud_trigger(baud_trigger),
    .baud_enable (baud_enable),
    .baud_status (baud_status),
    .baud_tick   (baud_tick),
    .baud_finish (baud_finish),
    .tx          (tx),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_err   (frame_err),
    .err_clr     (err_clr)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One frame: predict the winner, wait for ack, play the baud generator.
  // early_k: issue finish after that many ticks; rst_k: reset at that tick slot.
  // drop: 0 keep valids, 1 drop winner, 2 drop both.
  task automatic run_frame(input int sdelay, input int gap, input int early_k,
                           input int rst_k, input int drop, input bit en_off);
    exp_t e;
    logic w;
    int   lat;
    bit   got;
    if (req0_valid && req1_valid) w = RR ? rr_ptr : 1'b0;
    else                          w = req0_valid ? 1'b0 : 1'b1;
    rr_ptr = ~w;
    e.id   = w;
    e.data = w ? req1_data : req0_data;
    sb_q.push_back(e);
    got = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge sysclk);
      lat = i;
      if (req0_ack || req1_ack) begin
        got = 1;
        break;
      end
    end
    chk("ack_latency", lat, 1);
    if (!got) begin
      sb_q.delete();
      return;
    end
    if (drop != 0) begin
      if (w) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
    end
    if (drop == 2) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    if (en_off) en = 1'b0;
    chk("trig_high", baud_trigger, 1);
    for (int i = 0; i < sdelay; i++) begin
      @(negedge sysclk);
      chk("trig_held", baud_trigger, 1);
    end
    baud_status = 1'b1;
    @(negedge sysclk);
    chk("trig_dropped", baud_trigger, 0);
    for (int k = 0; k < NBITS; k++) begin
      if (k == early_k) break;
      repeat (gap - 1) @(negedge sysclk);
      if (k == rst_k) begin
        reset = 1'b1;
        @(negedge sysclk);
        reset       = 1'b0;
        baud_status = 1'b0;
        rr_ptr      = 1'b0;
        en          = 1'b1;
        return;
      end
      baud_tick = 1'b1;
      @(negedge sysclk);
      baud_tick = 1'b0;
    end
    repeat (gap - 1) @(negedge sysclk);
    baud_finish = 1'b1;
    @(negedge sysclk);
    baud_finish = 1'b0;
    baud_status = 1'b0;
    en          = 1'b1;
  endtask

  // Monitor: pops the scoreboard on ack and tracks the expected line level.
  initial begin : monitor
    exp_t             e;
    logic [NBITS-1:0] bits;
    int               bi;
    bit               in_frame;
    bit               early;
    logic             exp_tx, exp_busy, exp_err, exp_gid;
    logic             s_tick, s_fin, s_clr, s_rst;
    bits = '1; bi = 0; in_frame = 0;
    exp_tx = 1'b1; exp_busy = 1'b0; exp_err = 1'b0; exp_gid = 1'b0;
    forever begin
      @(posedge sysclk);
      s_tick = baud_tick;
      s_fin  = baud_finish;
      s_clr  = err_clr;
      s_rst  = reset;
      #1;
      if (s_rst) begin
        in_frame = 0;
        exp_tx = 1'b1; exp_busy = 1'b0; exp_err = 1'b0; exp_gid = 1'b0;
        chk("rst_ack0", req0_ack, 0);
        chk("rst_ack1", req1_ack, 0);
        chk("rst_trig", baud_trigger, 0);
      end else begin
        early = 0;
        if (req0_ack || req1_ack) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_ack", {req1_ack, req0_ack}, 0);
          end else begin
            e = sb_q.pop_front();
            chk("ack0", req0_ack, !e.id);
            chk("ack1", req1_ack, e.id);
            exp_gid  = e.id;
            bits     = {1'b1, e.data, 1'b0};
            bi       = 0;
            in_frame = 1;
            exp_busy = 1'b1;
          end
        end else if (in_frame) begin
          if (s_tick && bi < NBITS) begin
            exp_tx = bits[bi];
            bi++;
          end
          if (s_fin) begin
            early    = (bi < NBITS);
            in_frame = 0;
            exp_busy = 1'b0;
            exp_tx   = 1'b1;
          end
        end
        if (early)      exp_err = 1'b1;
        else if (s_clr) exp_err = 1'b0;
      end
      chk("tx", tx, exp_tx);
      chk("busy", busy, exp_busy);
      chk("frame_err", frame_err, exp_err);
      chk("grant_id", grant_id, exp_gid);
      chk("baud_enable", baud_enable, en);
    end
  end

  initial begin : stimulus
    checks = 0; errors = 0; rr_ptr = 1'b0;
    reset = 1'b1; en = 1'b0;
    req0_valid = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_data = '0;
    baud_status = 1'b0; baud_tick = 1'b0; baud_finish = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);

    // Single frame, 0xA5, ticks every 16 cycles.
    en = 1'b1; req0_valid = 1'b1; req0_data = 8'hA5;
    run_frame(0, 16, -1, -1, 1, 0);

    // Enable gate: requester 1 waits while en is low.
    en = 1'b0; req1_valid = 1'b1; req1_data = 8'h3C;
    repeat (5) begin
      @(negedge sysclk);
      chk("gate_no_trig", baud_trigger, 0);
      chk("gate_no_ack", req1_ack, 0);
    end
    en = 1'b1;
    run_frame(1, 3, -1, -1, 1, 0);

    // Tie held over three frames.
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    run_frame(0, 2, -1, -1, 0, 0);
    run_frame(2, 3, -1, -1, 0, 0);
    run_frame(1, 2, -1, -1, 2, 0);

    // Early finish after the 4th tick, then clear the flag.
    req1_valid = 1'b1; req1_data = 8'h96;
    run_frame(0, 3, 4, -1, 1, 0);
    err_clr = 1'b1;
    @(negedge sysclk);
    err_clr = 1'b0;
    @(negedge sysclk);
    chk("err_cleared", frame_err, 0);

    // Slow generator start.
    req0_valid = 1'b1; req0_data = 8'h5A;
    run_frame(5, 2, -1, -1, 1, 0);

    // Reset at the 6th tick slot, then a normal frame.
    req0_valid = 1'b1; req0_data = 8'hC3;
    run_frame(0, 3, -1, 5, 1, 0);
    @(negedge sysclk);
    req1_valid = 1'b1; req1_data = 8'h7E;
    run_frame(0, 2, -1, -1, 1, 0);

    // Randomized traffic; losers keep their request pending.
    for (int f = 0; f < 10; f++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) begin
        req0_valid = 1'b1; req0_data = DATA_W'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 1) == 1) begin
        req1_valid = 1'b1; req1_data = DATA_W'($urandom);
      end
      if (!req0_valid && !req1_valid) begin
        req0_valid = 1'b1; req0_data = DATA_W'($urandom);
      end
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)), -1, -1,
                (f == 9) ? 2 : 1, $urandom_range(0, 1) == 1);
    end

    repeat (5) @(negedge sysclk);
    chk("queue_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
